// File: rtl/cpu_pkg.sv
// Shared fetch/execute types: assembler state encoding, decoded packet
// layout and the opcode values both stages need to agree on.
package cpu_pkg;

  // Byte-assembly FSM states of the fetch stage.
  typedef enum logic [2:0] {
    FetchOp   = 3'd0,
    FetchReg  = 3'd1,
    FetchImm1 = 3'd2,
    FetchImm2 = 3'd3,
    Halted    = 3'd4
  } fetch_state_t;

  // One fully decoded instruction as handed to execute.
  typedef struct packed {
    logic [4:0]  opcode;
    logic [2:0]  dst;
    logic        hasimm1;
    logic        hasimm2;
    logic [2:0]  src1;
    logic [2:0]  src2;
    logic [7:0]  imm1;
    logic [7:0]  imm2;
    logic [15:0] pc;
    logic [15:0] next_pc;
  } fetch_pkt_t;

  // Control-flow opcodes; execute redirects fetch on jmp/cal/ret.
  localparam logic [4:0] OP_JMP = 5'b11000;
  localparam logic [4:0] OP_CAL = 5'b11001;
  localparam logic [4:0] OP_RET = 5'b11010;
  localparam logic [4:0] OP_HLT = 5'b11111;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of decoded fetch packets between the assembler and execute.
// The head entry drives the consumer directly; flush empties it in one edge
// and wins over any push or pop in the same cycle.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  fetch_pkt_t push_pkt,
  input  logic       pop,
  output fetch_pkt_t head_pkt,
  output logic       head_valid,
  output logic       full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_pkt_t       mem_q [DEPTH];
  fetch_pkt_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_fire;
  logic             pop_fire;

  // Pointer advance with explicit wrap so non-trivial depths stay correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count_q != '0);
  assign full       = (count_q == FULL_CNT);
  assign push_fire  = push && !flush;
  assign pop_fire   = pop && head_valid && !flush;
  assign head_pkt   = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_fire) begin
        mem_d[wr_ptr_q] = push_pkt;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop_fire) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(push_fire) - CNT_W'(pop_fire);
    end
  end

  // Queue registers; reset clears entries so the head reads all-zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Byte-serial instruction fetch: walks the 8-bit ROM, assembles 2..4 byte
// instructions into decoded packets and queues them for execute.
// Optional build macro IFETCH_HALT_STOP_EN: stop fetching after a halt
// opcode is pushed until a redirect arrives.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 2,
  parameter logic [15:0] RESET_PC    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] rom_addr,
  input  logic [7:0]  rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_opcode,
  output logic [2:0]  out_dst,
  output logic        out_hasimm1,
  output logic        out_hasimm2,
  output logic [2:0]  out_src1,
  output logic [2:0]  out_src2,
  output logic [7:0]  out_imm1,
  output logic [7:0]  out_imm2,
  output logic [15:0] out_pc,
  output logic [15:0] out_next_pc,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc
);

  fetch_state_t state_q, state_d;
  logic [15:0]  fetch_pc_q, fetch_pc_d;
  logic [4:0]   opcode_q, opcode_d;
  logic [2:0]   dst_q, dst_d;
  logic [15:0]  pc_q, pc_d;
  logic         hasimm1_q, hasimm1_d;
  logic         hasimm2_q, hasimm2_d;
  logic [2:0]   src1_q, src1_d;
  logic [2:0]   src2_q, src2_d;
  logic [7:0]   imm1_q, imm1_d;

  logic         push_req;
  fetch_pkt_t   push_pkt;
  fetch_pkt_t   head_pkt;
  logic         q_valid;
  logic         q_full;
  logic         pop_now;
  logic         slot_free;

  // A pop this cycle frees the slot the next instruction will need, so
  // starting an instruction only requires room at its eventual push.
  assign pop_now   = q_valid && out_ready;
  assign slot_free = !q_full || pop_now;
  assign rom_addr  = fetch_pc_q;

  // Assembler next-state, byte latching and push generation.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    opcode_d   = opcode_q;
    dst_d      = dst_q;
    pc_d       = pc_q;
    hasimm1_d  = hasimm1_q;
    hasimm2_d  = hasimm2_q;
    src1_d     = src1_q;
    src2_d     = src2_q;
    imm1_d     = imm1_q;
    push_req   = 1'b0;

    // The final byte of a packet comes straight from rom_data; the rest
    // from the latches filled on earlier cycles.
    push_pkt         = '0;
    push_pkt.opcode  = opcode_q;
    push_pkt.dst     = dst_q;
    push_pkt.pc      = pc_q;
    push_pkt.hasimm1 = hasimm1_q;
    push_pkt.hasimm2 = hasimm2_q;
    push_pkt.src1    = src1_q;
    push_pkt.src2    = src2_q;
    push_pkt.imm1    = imm1_q;
    push_pkt.imm2    = 8'h00;
    push_pkt.next_pc = fetch_pc_q + 16'd1;

    case (state_q)
      FetchOp: begin
        if (slot_free) begin
          opcode_d   = rom_data[4:0];
          dst_d      = rom_data[7:5];
          pc_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 16'd1;
          state_d    = FetchReg;
        end
      end
      FetchReg: begin
        hasimm1_d  = rom_data[7];
        hasimm2_d  = rom_data[6];
        src1_d     = rom_data[5:3];
        src2_d     = rom_data[2:0];
        imm1_d     = 8'h00;
        fetch_pc_d = fetch_pc_q + 16'd1;
        push_pkt.hasimm1 = rom_data[7];
        push_pkt.hasimm2 = rom_data[6];
        push_pkt.src1    = rom_data[5:3];
        push_pkt.src2    = rom_data[2:0];
        push_pkt.imm1    = 8'h00;
        if (rom_data[7]) begin
          state_d = FetchImm1;
        end else if (rom_data[6]) begin
          state_d = FetchImm2;
        end else begin
          push_req = 1'b1;
        end
      end
      FetchImm1: begin
        imm1_d        = rom_data;
        fetch_pc_d    = fetch_pc_q + 16'd1;
        push_pkt.imm1 = rom_data;
        if (hasimm2_q) begin
          state_d = FetchImm2;
        end else begin
          push_req = 1'b1;
        end
      end
      FetchImm2: begin
        fetch_pc_d    = fetch_pc_q + 16'd1;
        push_pkt.imm2 = rom_data;
        push_req      = 1'b1;
      end
      Halted: begin
        // Address frozen; only a redirect or reset leaves this state.
      end
      default: begin
        state_d = FetchOp;
      end
    endcase

    if (push_req) begin
      state_d = FetchOp;
`ifdef IFETCH_HALT_STOP_EN
      if (push_pkt.opcode == OP_HLT) begin
        state_d = Halted;
      end
`endif
    end

    // Redirect abandons any partial instruction and restarts at the target.
    if (redirect_valid) begin
      state_d    = FetchOp;
      fetch_pc_d = redirect_pc;
      push_req   = 1'b0;
    end
  end

  // Assembler state, fetch address and partial-instruction latches.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= FetchOp;
      fetch_pc_q <= RESET_PC;
      opcode_q   <= '0;
      dst_q      <= '0;
      pc_q       <= '0;
      hasimm1_q  <= 1'b0;
      hasimm2_q  <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      imm1_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      opcode_q   <= opcode_d;
      dst_q      <= dst_d;
      pc_q       <= pc_d;
      hasimm1_q  <= hasimm1_d;
      hasimm2_q  <= hasimm2_d;
      src1_q     <= src1_d;
      src2_q     <= src2_d;
      imm1_q     <= imm1_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push_req),
    .push_pkt   (push_pkt),
    .pop        (out_ready),
    .head_pkt   (head_pkt),
    .head_valid (q_valid),
    .full       (q_full)
  );

  assign out_valid   = q_valid;
  assign out_opcode  = head_pkt.opcode;
  assign out_dst     = head_pkt.dst;
  assign out_hasimm1 = head_pkt.hasimm1;
  assign out_hasimm2 = head_pkt.hasimm2;
  assign out_src1    = head_pkt.src1;
  assign out_src2    = head_pkt.src2;
  assign out_imm1    = head_pkt.imm1;
  assign out_imm2    = head_pkt.imm2;
  assign out_pc      = head_pkt.pc;
  assign out_next_pc = head_pkt.next_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed timing scenarios followed by a randomized
// run checked against an instruction-level decode of the ROM image.
module tb_instr_fetch;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_opcode;
  logic [2:0]  out_dst;
  logic        out_hasimm1, out_hasimm2;
  logic [2:0]  out_src1, out_src2;
  logic [7:0]  out_imm1, out_imm2;
  logic [15:0] out_pc, out_next_pc;
  logic        redirect_valid;
  logic [15:0] redirect_pc;

  logic [15:0] w_rom_addr;
  logic [7:0]  w_rom_data;
  logic        w_valid;
  logic        w_ready;
  logic [4:0]  w_opcode;
  logic [2:0]  w_dst;
  logic        w_hasimm1, w_hasimm2;
  logic [2:0]  w_src1, w_src2;
  logic [7:0]  w_imm1, w_imm2;
  logic [15:0] w_pc, w_next_pc;
  logic        w_redirect_valid;
  logic [15:0] w_redirect_pc;

  logic [7:0] rom_mem [0:65535];
  assign rom_data   = rom_mem[rom_addr];
  assign w_rom_data = rom_mem[w_rom_addr];

  instr_fetch #(.QUEUE_DEPTH(2), .RESET_PC(16'h0000)) u_dut (
    .clk(clk), .rst_n(rst_n), .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_dst(out_dst), .out_hasimm1(out_hasimm1), .out_hasimm2(out_hasimm2),
    .out_src1(out_src1), .out_src2(out_src2), .out_imm1(out_imm1),
    .out_imm2(out_imm2), .out_pc(out_pc), .out_next_pc(out_next_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  // Second instance exercising a reset address at the top of the space.
  instr_fetch #(.QUEUE_DEPTH(2), .RESET_PC(16'hFFFF)) u_wrap (
    .clk(clk), .rst_n(rst_n), .rom_addr(w_rom_addr), .rom_data(w_rom_data),
    .out_valid(w_valid), .out_ready(w_ready), .out_opcode(w_opcode),
    .out_dst(w_dst), .out_hasimm1(w_hasimm1), .out_hasimm2(w_hasimm2),
    .out_src1(w_src1), .out_src2(w_src2), .out_imm1(w_imm1),
    .out_imm2(w_imm2), .out_pc(w_pc), .out_next_pc(w_next_pc),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] out_bits();
    return {out_opcode, out_dst, out_hasimm1, out_hasimm2, out_src1, out_src2,
            out_imm1, out_imm2, out_pc, out_next_pc};
  endfunction

  function automatic logic [63:0] w_bits();
    return {w_opcode, w_dst, w_hasimm1, w_hasimm2, w_src1, w_src2,
            w_imm1, w_imm2, w_pc, w_next_pc};
  endfunction

  function automatic logic [63:0] pkt(input logic [4:0] op, input logic [2:0] dst,
                                      input logic h1, input logic h2,
                                      input logic [2:0] s1, input logic [2:0] s2,
                                      input logic [7:0] i1, input logic [7:0] i2,
                                      input logic [15:0] pc, input logic [15:0] npc);
    return {op, dst, h1, h2, s1, s2, i1, i2, pc, npc};
  endfunction

  // Instruction-level decode of the ROM at pc; low 16 bits are the next pc.
  function automatic logic [63:0] ref_decode(input logic [15:0] pc);
    logic [15:0] a;
    logic [7:0]  b0, b1, i1, i2;
    b0 = rom_mem[pc];
    a  = pc + 16'd1;
    b1 = rom_mem[a];
    a  = pc + 16'd2;
    i1 = 8'h00;
    i2 = 8'h00;
    if (b1[7]) begin i1 = rom_mem[a]; a = a + 16'd1; end
    if (b1[6]) begin i2 = rom_mem[a]; a = a + 16'd1; end
    return pkt(b0[4:0], b0[7:5], b1[7], b1[6], b1[5:3], b1[2:0], i1, i2, pc, a);
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 65536; i++) rom_mem[i] = 8'h00;
  endtask

  // Hold reset for two edges, check reset state, then release into cycle 1.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    tick();
    tick();
    check({tag, "_rst_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_rst_addr"}, 64'(rom_addr), 64'h0000);
    check({tag, "_rst_fields"}, out_bits(), 64'd0);
    check({tag, "_rst_waddr"}, 64'(w_rom_addr), 64'hFFFF);
    rst_n = 1'b1;
  endtask

  logic [15:0] exp_pc;
  logic [63:0] exp_pkt;
  logic        model_halted;
  int          pops;

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 16'h0000;
    w_ready = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc = 16'h0000;

    // 2-byte instruction, plus the wrap instance reading FFFF then 0000.
    clear_rom();
    rom_mem[16'h0000] = 8'h21;
    rom_mem[16'h0001] = 8'h0A;
    rom_mem[16'hFFFF] = 8'h21;
    do_reset("t1");
    out_ready = 1'b1;
    check("t1_c1_addr", 64'(rom_addr), 64'h0000);
    check("t1_c1_waddr", 64'(w_rom_addr), 64'hFFFF);
    tick();
    check("t1_c2_valid", 64'(out_valid), 64'd0);
    check("t1_c2_waddr", 64'(w_rom_addr), 64'h0000);
    tick();
    check("t1_c3_valid", 64'(out_valid), 64'd1);
    check("t1_c3_pkt", out_bits(), pkt(5'd1, 3'd1, 1'b0, 1'b0, 3'd1, 3'd2, 8'h00, 8'h00, 16'h0000, 16'h0002));
    check("t1_c3_wvalid", 64'(w_valid), 64'd1);
    check("t1_c3_wpkt", w_bits(), pkt(5'd1, 3'd1, 1'b0, 1'b0, 3'd4, 3'd1, 8'h00, 8'h00, 16'hFFFF, 16'h0001));

    // 4-byte instruction with both immediates.
    clear_rom();
    rom_mem[0] = 8'h40; rom_mem[1] = 8'hC0; rom_mem[2] = 8'h12; rom_mem[3] = 8'h34;
    do_reset("t2");
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("t2_c4_valid", 64'(out_valid), 64'd0);
    check("t2_c4_addr", 64'(rom_addr), 64'h0003);
    tick();
    check("t2_c5_valid", 64'(out_valid), 64'd1);
    check("t2_c5_pkt", out_bits(), pkt(5'd0, 3'd2, 1'b1, 1'b1, 3'd0, 3'd0, 8'h12, 8'h34, 16'h0000, 16'h0004));
    check("t2_c5_addr", 64'(rom_addr), 64'h0004);

    // Backpressure: two packets fill the queue, fetch then holds.
    clear_rom();
    rom_mem[0] = 8'h01; rom_mem[2] = 8'h02; rom_mem[4] = 8'h03;
    do_reset("t3");
    tick(); tick();
    check("t3_c3_pkt", out_bits(), pkt(5'd1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 16'h0000, 16'h0002));
    tick(); tick();
    check("t3_c5_addr", 64'(rom_addr), 64'h0004);
    tick(); tick(); tick();
    check("t3_c8_addr", 64'(rom_addr), 64'h0004);
    check("t3_c8_pkt", out_bits(), pkt(5'd1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 16'h0000, 16'h0002));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_c9_addr", 64'(rom_addr), 64'h0005);
    check("t3_c9_pkt", out_bits(), pkt(5'd2, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 16'h0002, 16'h0004));
    tick();
    check("t3_c10_addr", 64'(rom_addr), 64'h0006);
    tick();
    check("t3_c11_addr", 64'(rom_addr), 64'h0006);
    check("t3_c11_pkt", out_bits(), pkt(5'd2, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 16'h0002, 16'h0004));

    // Redirect during FetchImm1 with one packet queued.
    clear_rom();
    rom_mem[0] = 8'h05; rom_mem[2] = 8'h06; rom_mem[3] = 8'h80; rom_mem[4] = 8'hAA;
    rom_mem[16'h0100] = 8'h07; rom_mem[16'h0101] = 8'h1B;
    do_reset("t4");
    tick(); tick(); tick(); tick();
    check("t4_c5_addr", 64'(rom_addr), 64'h0004);
    check("t4_c5_valid", 64'(out_valid), 64'd1);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    check("t4_c6_valid", 64'(out_valid), 64'd0);
    check("t4_c6_addr", 64'(rom_addr), 64'h0100);
    tick();
    check("t4_c7_valid", 64'(out_valid), 64'd0);
    tick();
    check("t4_c8_valid", 64'(out_valid), 64'd1);
    check("t4_c8_pkt", out_bits(), pkt(5'd7, 3'd0, 1'b0, 1'b0, 3'd3, 3'd3, 8'h00, 8'h00, 16'h0100, 16'h0102));

    // Halt opcode followed by more code, then a redirect.
    clear_rom();
    rom_mem[0] = 8'h1F; rom_mem[2] = 8'h01; rom_mem[4] = 8'h02;
    do_reset("t6");
    out_ready = 1'b1;
    tick(); tick();
    check("t6_c3_pkt", out_bits(), pkt(5'h1F, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 16'h0000, 16'h0002));
    tick(); tick();
`ifdef IFETCH_HALT_STOP_EN
    check("t6_c5_valid", 64'(out_valid), 64'd0);
    check("t6_c5_addr", 64'(rom_addr), 64'h0002);
`else
    check("t6_c5_valid", 64'(out_valid), 64'd1);
    check("t6_c5_pkt", out_bits(), pkt(5'd1, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 16'h0002, 16'h0004));
`endif
    redirect_valid = 1'b1;
    redirect_pc = 16'h0004;
    tick();
    redirect_valid = 1'b0;
    check("t6_c6_addr", 64'(rom_addr), 64'h0004);
    tick(); tick();
    check("t6_c8_pkt", out_bits(), pkt(5'd2, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 8'h00, 8'h00, 16'h0004, 16'h0006));

    // Randomized run: every pop outside a redirect cycle must be the next
    // instruction of the sequential program starting at the last target.
    for (int i = 0; i < 65536; i++) rom_mem[i] = 8'($urandom);
    do_reset("rnd");
    exp_pc = 16'h0000;
    model_halted = 1'b0;
    pops = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 49) == 0);
      redirect_pc = 16'($urandom);
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        model_halted = 1'b0;
      end else if (model_halted) begin
        check("rnd_halt_quiet", 64'(out_valid), 64'd0);
      end else if (out_valid && out_ready) begin
        exp_pkt = ref_decode(exp_pc);
        $display("[TB] pop pc=%04h op=%02h next=%04h", out_pc, out_opcode, out_next_pc);
        check("rnd_pkt", out_bits(), exp_pkt);
        exp_pc = exp_pkt[15:0];
        pops++;
`ifdef IFETCH_HALT_STOP_EN
        if (exp_pkt[63:59] == OP_HLT) model_halted = 1'b1;
`endif
      end
      tick();
    end
    redirect_valid = 1'b0;
    check("rnd_progress", 64'(pops > 50), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Byte-serial instruction fetch stage that sits directly upstream of the execute core. Walks the 8-bit ROM, assembles the variable-length instruction (opcode/dst byte, register/immediate-flag byte, up to two immediate bytes) into one decoded packet, and hands packets to execute through a small queue with a valid/ready handshake. Execute redirects fetch on taken jumps, calls and returns.

## Interface
- QUEUE_DEPTH, 2, decoded-packet queue entries; power of two, at least 1
- RESET_PC, 16'h0000, first fetch address after reset
- clk  in  1  single clock, all state on posedge
- rst_n  in  1  reset; synchronous, active-low
- rom_addr  out  16  ROM byte address; ROM returns `rom_data` combinationally the same cycle
- rom_data  in  8  ROM byte at `rom_addr`
- out_valid  out  1  head packet valid
- out_ready  in  1  execute accepts head packet; pop when `out_valid && out_ready`
- out_opcode  out  5  byte0[4:0]
- out_dst  out  3  byte0[7:5]
- out_hasimm1 / out_hasimm2  out  1 each  byte1[7] / byte1[6]
- out_src1 / out_src2  out  3 each  byte1[5:3] / byte1[2:0]
- out_imm1 / out_imm2  out  8 each  immediate bytes; 0 when the flag is clear
- out_pc  out  16  address of byte0
- out_next_pc  out  16  address following the last byte, i.e. the return address for `cal`
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  16  new fetch address

## Operation
- Assembler FSM states: FetchOp, FetchReg, FetchImm1, FetchImm2, Halted.
- `rom_addr` = `fetch_pc`. Each cycle spent in a Fetch* state consumes `rom_data` and increments `fetch_pc` modulo 2^16, so 16'hFFFF wraps to 16'h0000 and a packet may straddle the wrap.
- FetchOp: consume byte only if a queue slot is free (count < QUEUE_DEPTH, or a pop happens this cycle). Otherwise hold with `fetch_pc` unchanged. Latch opcode, dst and `out_pc`, then go to FetchReg.
- FetchReg: latch flags and srcs. Next state is FetchImm1 if byte[7], else FetchImm2 if byte[6], else push this cycle and return to FetchOp.
- FetchImm1: latch imm1. Next state is FetchImm2 if hasimm2, else push and return to FetchOp.
- FetchImm2: latch imm2, push, return to FetchOp.
- The push carries the final byte straight from `rom_data`. `out_next_pc` = `fetch_pc` + 1 at push time.
- Queue count changes by +1 on push, −1 on pop, and stays the same when both happen in one cycle. Push is never blocked, because the slot was reserved in FetchOp.
- Redirect has priority over everything in its cycle:
  - queue emptied, and any same-cycle push and pop are discarded;
  - partial assembly is abandoned;
  - `fetch_pc` <= `redirect_pc`, state <= FetchOp.
- The consumer must not rely on a packet popped in the redirect cycle; execute asserts redirect only on the cycle it retires the redirecting packet.

## Timing
- Reset values:
  - `out_valid` 0, queue count 0;
  - all `out_*` fields 0;
  - `rom_addr` = RESET_PC;
  - state FetchOp.
- An N-byte instruction (N = 2..4) occupies N fetch cycles. It is pushed at the end of cycle N, and `out_valid` rises the following cycle. Throughput is one packet per N cycles with no bubbles while space is available.
- Redirect asserted in cycle T: `rom_addr` = `redirect_pc` in T+1; a 2-byte target is valid in T+3.
- `out_*` are driven from the queue head register. They hold stable while `out_valid && !out_ready`.
- Reset asserted mid-instruction discards everything at the next edge.

## Configuration
- IFETCH_HALT_STOP_EN defined:
  - after pushing opcode 5'b11111, the FSM enters Halted;
  - in Halted, `rom_addr` is frozen and no further pushes occur;
  - Halted is left only by redirect or reset.
- Undefined: the halt opcode is an ordinary packet and fetch continues sequentially. The Halted state is never entered.

## Structure
- `cpu_pkg` holds:
  - `fetch_state_t` enum;
  - `fetch_pkt_t` packed struct of all `out_*` fields;
  - opcode constants (OP_HLT = 5'b11111, jump/call/ret codes), shared with execute.
- Sub-module `fetch_queue`: parameterised `fetch_pkt_t` FIFO (depth, count, push/pop/flush). The FSM and PC logic stay in `instr_fetch`.

## Test plan
- ROM {8'h21, 8'h0A} (add r1, src1=1, src2=2, no imm), `out_ready`=1 → packet at cycle 3 with opcode 1, dst 1, src1 1, src2 2, pc 0, next_pc 2.
- ROM {8'h40, 8'hC0, 8'h12, 8'h34} → one packet with hasimm1=1, hasimm2=1, imm1 8'h12, imm2 8'h34, next_pc 4; `rom_addr` = 4 on the following cycle.
- `out_ready`=0 with DEPTH=2 and 2-byte instructions → two packets queued, then FSM holds in FetchOp with `rom_addr` stable. Raise `out_ready` for one cycle → fetch resumes that same cycle.
- Redirect to 16'h0100 during FetchImm1 with one packet queued → `out_valid` 0 next cycle, `rom_addr` 16'h0100, first new packet valid at T+3 (2-byte target).
- RESET_PC = 16'hFFFF, 2-byte instruction → bytes read from FFFF then 0000; pc FFFF, next_pc 0001.
- Halt byte 8'h1F followed by junk: with IFETCH_HALT_STOP_EN, exactly one halt packet is pushed and `rom_addr` freezes; without the macro, junk packets follow.
